// File: rtl/poly_sequencer_if.sv
// Coefficient stream (valid/ready) and result (valid/ack) channels of poly_sequencer.
// master is the front-end/display side, slave is the sequencer.
interface poly_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             coef_valid;
    logic [WIDTH-1:0] coef_data;
    logic             coef_ready;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             result_ack;

    modport master (
        output coef_valid, coef_data, result_ack,
        input  coef_ready, result_valid, result, ovf
    );

    modport slave (
        input  coef_valid, coef_data, result_ack,
        output coef_ready, result_valid, result, ovf
    );
endinterface

// File: rtl/poly_sequencer.sv
// Horner-rule polynomial evaluator sharing one multiply/add datapath across
// alternating MUL and ADD cycles; coefficients arrive highest order first.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; last result still visible on result
// LOAD   | coef_ready high, waiting for the next coefficient
// MUL    | acc <= acc * x (low half), overflow if high half nonzero
// ADD    | acc <= acc + coef, overflow on carry; loop or finish
// DONE   | result_valid high until result_ack
module poly_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEG_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [DEG_W-1:0]   degree,
    input  logic               abort,
    output logic               busy,
    poly_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [DEG_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   coef_q, coef_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;

    assign prod = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
    assign sum  = {1'b0, acc_q} + {1'b0, coef_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            coef_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        // abort leaves acc/ovf untouched so the partial value stays observable
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_d     = x_in;
                        cnt_d   = degree;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.coef_valid) begin
                        coef_d  = bus.coef_data;
                        state_d = S_MUL;
                    end
                end
                S_MUL: begin
                    acc_d   = prod[WIDTH-1:0];
                    ovf_d   = ovf_q | (|prod[2*WIDTH-1:WIDTH]);
                    state_d = S_ADD;
                end
                S_ADD: begin
                    acc_d = sum[WIDTH-1:0];
                    ovf_d = ovf_q | sum[WIDTH];
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q - DEG_W'(1);
                        state_d = S_LOAD;
                    end
                end
                S_DONE: begin
                    if (bus.result_ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.coef_ready   = (state_q == S_LOAD) && !abort;
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.result       = acc_q;
    assign bus.ovf          = ovf_q;
    assign busy             = (state_q != S_IDLE);

endmodule
